// File: rtl/renderer_blend_scheduler_if.sv
// Bundle of the span-fill scheduler's command, mixer and VRAM signals.
// The master side is the scheduler; the slave side is the command decoder, mixer and VRAM port.
interface renderer_blend_scheduler_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_address;
  logic [LEN_WIDTH-1:0]  cmd_length;
  logic [15:0]           cmd_color;

  logic [3:0] mix_original_red, mix_original_green, mix_original_blue;
  logic [3:0] mix_color_red, mix_color_green, mix_color_blue;
  logic [3:0] mix_alpha;
  logic [3:0] mix_final_red, mix_final_green, mix_final_blue;

  logic                  rd_request;
  logic [ADDR_WIDTH-1:0] rd_address;
  logic                  rd_ack;
  logic                  rd_valid;
  logic [11:0]           rd_data;

  logic                  wr_request;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic [11:0]           wr_data;
  logic                  wr_ack;

  logic busy;
  logic done;

  modport master (
    input  cmd_valid, cmd_address, cmd_length, cmd_color,
    output cmd_ready,
    output mix_original_red, mix_original_green, mix_original_blue,
    output mix_color_red, mix_color_green, mix_color_blue, mix_alpha,
    input  mix_final_red, mix_final_green, mix_final_blue,
    output rd_request, rd_address,
    input  rd_ack, rd_valid, rd_data,
    output wr_request, wr_address, wr_data,
    input  wr_ack,
    output busy, done
  );

  modport slave (
    output cmd_valid, cmd_address, cmd_length, cmd_color,
    input  cmd_ready,
    input  mix_original_red, mix_original_green, mix_original_blue,
    input  mix_color_red, mix_color_green, mix_color_blue, mix_alpha,
    output mix_final_red, mix_final_green, mix_final_blue,
    input  rd_request, rd_address,
    output rd_ack, rd_valid, rd_data,
    input  wr_request, wr_address, wr_data,
    output wr_ack,
    input  busy, done
  );
endinterface

// File: rtl/renderer_blend_scheduler.sv
// Span-fill scheduler: reads destination pixels, streams them through the external alpha
// mixer and writes results back via a credit-limited FIFO so the mixer never stalls.
module renderer_blend_scheduler #(
  parameter int ADDR_WIDTH    = 16,
  parameter int LEN_WIDTH     = 10,
  parameter int MIXER_LATENCY = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input logic i_master_clk,
  input logic i_reset,
  renderer_blend_scheduler_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 2;

  typedef enum logic [2:0] {IDLE, BLEND, FILL, DRAIN, DONE} state_t;
  state_t state;

  logic [ADDR_WIDTH-1:0]    base;
  logic [ADDR_WIDTH-1:0]    rd_addr;
  logic [LEN_WIDTH-1:0]     length;
  logic [LEN_WIDTH-1:0]     reads_acked;
  logic [LEN_WIDTH-1:0]     fills;
  logic [LEN_WIDTH-1:0]     writes_acked;
  logic [15:0]              color;
  logic                     cmd_ready;
  logic                     busy;
  logic                     done;

  logic [MIXER_LATENCY-1:0] pipe_valid;
  logic [CNT_W-1:0]         outstanding;
  logic [CNT_W-1:0]         occupancy;
  logic [CNT_W-1:0]         in_flight;
  logic [11:0]              fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;

  logic        accept;
  logic        rd_fire;
  logic        rd_take;
  logic        fifo_full;
  logic        fill_push;
  logic        push;
  logic        pop;
  logic [11:0] push_data;

  // Every pixel already committed to a FIFO slot: buffered, inside the mixer, or awaiting read data.
  always_comb begin
    in_flight = occupancy + outstanding;
    for (int i = 0; i < MIXER_LATENCY; i++) begin
      in_flight = in_flight + CNT_W'(pipe_valid[i]);
    end
  end

  assign accept    = bus.cmd_valid && cmd_ready;
  assign rd_fire   = bus.rd_request && bus.rd_ack;
  assign rd_take   = bus.rd_valid && (outstanding != '0);
  assign fifo_full = (occupancy == CNT_W'(FIFO_DEPTH));
  assign fill_push = (state == FILL) && !fifo_full;
  assign push      = fill_push || pipe_valid[MIXER_LATENCY-1];
  assign pop       = (occupancy != '0) && bus.wr_ack;
  assign push_data = fill_push ? color[11:0]
                               : {bus.mix_final_red, bus.mix_final_green, bus.mix_final_blue};

  assign bus.cmd_ready  = cmd_ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.rd_request = (state == BLEND) && (in_flight < CNT_W'(FIFO_DEPTH));
  assign bus.rd_address = rd_addr;
  assign bus.wr_request = (occupancy != '0);
  assign bus.wr_data    = bus.wr_request ? fifo_mem[rd_ptr] : 12'h000;
  assign bus.wr_address = base + ADDR_WIDTH'(writes_acked);

  assign bus.mix_original_red   = bus.rd_valid ? bus.rd_data[11:8] : 4'h0;
  assign bus.mix_original_green = bus.rd_valid ? bus.rd_data[7:4]  : 4'h0;
  assign bus.mix_original_blue  = bus.rd_valid ? bus.rd_data[3:0]  : 4'h0;
  assign bus.mix_alpha          = color[15:12];
  assign bus.mix_color_red      = color[11:8];
  assign bus.mix_color_green    = color[7:4];
  assign bus.mix_color_blue     = color[3:0];

  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      base         <= '0;
      rd_addr      <= '0;
      length       <= '0;
      color        <= '0;
      reads_acked  <= '0;
      fills        <= '0;
      writes_acked <= '0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pop) writes_acked <= writes_acked + LEN_WIDTH'(1);
      if (rd_fire) begin
        rd_addr     <= rd_addr + ADDR_WIDTH'(1);
        reads_acked <= reads_acked + LEN_WIDTH'(1);
      end
      if (fill_push) fills <= fills + LEN_WIDTH'(1);

      case (state)
        IDLE: begin
          if (accept) begin
            base         <= bus.cmd_address;
            rd_addr      <= bus.cmd_address;
            length       <= bus.cmd_length;
            color        <= bus.cmd_color;
            reads_acked  <= '0;
            fills        <= '0;
            writes_acked <= '0;
            cmd_ready    <= 1'b0;
            busy         <= 1'b1;
            // A zero-length span or a fully transparent colour leaves VRAM untouched.
            if (bus.cmd_length == '0 || bus.cmd_color[15:12] == 4'h0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (bus.cmd_color[15:12] == 4'hf) begin
              state <= FILL;
            end else begin
              state <= BLEND;
            end
          end
        end
        BLEND: if (rd_fire && reads_acked == length - LEN_WIDTH'(1)) state <= DRAIN;
        FILL:  if (fill_push && fills == length - LEN_WIDTH'(1)) state <= DRAIN;
        DRAIN: begin
          if (writes_acked == length) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Resetting the valid pipe discards whatever the mixer still holds from an aborted span.
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      pipe_valid  <= '0;
      outstanding <= '0;
      occupancy   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      pipe_valid[0] <= rd_take;
      for (int i = 1; i < MIXER_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
      outstanding <= outstanding + CNT_W'(rd_fire) - CNT_W'(rd_take);
      occupancy   <= occupancy + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge i_master_clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end
endmodule
